// File: rtl/mips_exec_datapath.sv
// Execute/memory slice of the single-cycle MIPS core: ALU with flags, next-PC adders, 256-word data memory.
// Define ALU_OVF_EN to add the signed-overflow output ovf for ADD/SUB.
module mips_exec_datapath #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [3:0]  aluoperation,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] writedata,
  output logic [31:0] result,
  output logic        zero,
  output logic        lt,
  output logic        gt,
`ifdef ALU_OVF_EN
  output logic        ovf,
`endif
  output logic [31:0] nfpc,
  output logic [31:0] branchedpc,
  output logic [31:0] readdata
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [31:0]       mem_q [DEPTH];
  logic [4:0]        shamt;
  logic [31:0]       sum;
  logic [31:0]       diff;
  logic [ADDR_W-1:0] addr;
  logic              mem_we;

  assign shamt = data2[4:0];
  assign sum   = data1 + data2;
  assign diff  = data1 - data2;
  assign lt    = $signed(data1) < $signed(data2);
  assign gt    = $signed(data1) > $signed(data2);

  always_comb begin
    result = 32'h0;
    unique case (aluoperation)
      OP_AND:  result = data1 & data2;
      OP_OR:   result = data1 | data2;
      OP_ADD:  result = sum;
      OP_XOR:  result = data1 ^ data2;
      OP_SLL:  result = data1 << shamt;
      OP_SRL:  result = data1 >> shamt;
      OP_SUB:  result = diff;
      OP_SLT:  result = {31'b0, lt};
      OP_SRA:  result = $signed(data1) >>> shamt;
      OP_SLTU: result = {31'b0, data1 < data2};
      OP_NOR:  result = ~(data1 | data2);
      default: result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

`ifdef ALU_OVF_EN
  always_comb begin
    ovf = 1'b0;
    if (aluoperation == OP_ADD)
      ovf = (data1[31] == data2[31]) && (sum[31] != data1[31]);
    else if (aluoperation == OP_SUB)
      ovf = (data1[31] != data2[31]) && (diff[31] != data1[31]);
  end
`endif

  // PC is a word index, so the increment is 1 and the branch offset is not shifted.
  assign nfpc       = pc + 32'd1;
  assign branchedpc = nfpc + imm;

  // Upper result bits are ignored, so addresses alias modulo DEPTH.
  assign addr   = result[ADDR_W-1:0];
  assign mem_we = memwrite && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (mem_we) begin
      mem_q[addr] <= writedata;
    end
  end

  assign readdata = (memread && !rst) ? mem_q[addr] : 32'h0;

endmodule

// File: tb/tb_mips_exec_datapath.sv
// Directed self-checking bench for mips_exec_datapath.
module tb_mips_exec_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data1, data2, pc, imm, writedata;
  logic [3:0]  aluoperation;
  logic        memread, memwrite;
  logic [31:0] result, nfpc, branchedpc, readdata;
  logic        zero, lt, gt;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_exec_datapath dut (
    .clk(clk), .rst(rst), .data1(data1), .data2(data2),
    .aluoperation(aluoperation), .pc(pc), .imm(imm),
    .memread(memread), .memwrite(memwrite), .writedata(writedata),
    .result(result), .zero(zero), .lt(lt), .gt(gt),
`ifdef ALU_OVF_EN
    .ovf(ovf),
`endif
    .nfpc(nfpc), .branchedpc(branchedpc), .readdata(readdata)
  );

  // Drives data1 through ADD with data2=0 so result equals the desired address.
  task automatic set_addr(input logic [31:0] a);
    data1 = a; data2 = 32'h0; aluoperation = 4'b0010;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    set_addr(a); writedata = d; memwrite = 1'b1; memread = 1'b0;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; memwrite = 1'b0; memread = 1'b1; set_addr(32'h0);
    pc = 32'h0; imm = 32'h0; writedata = 32'h0;
    #3;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_read actual=%h expected=%h", readdata, 32'h0);
    end
    @(negedge clk); rst = 1'b0;
    write_word(32'd5, 32'hDEADBEEF);
    @(negedge clk); set_addr(32'd5); memread = 1'b1; #1;
    total++;
    if (readdata !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL pre_reset_read actual=%h expected=%h", readdata, 32'hDEADBEEF);
    end
    @(posedge clk); #2; rst = 1'b1; #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL async_reset_clear actual=%h expected=%h", readdata, 32'h0);
    end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL post_reset_stays_clear actual=%h expected=%h", readdata, 32'h0);
    end
  endtask

  task automatic test_alu_flags;
    @(negedge clk);
    memread = 1'b0;
    data1 = 32'd7; data2 = 32'd7; aluoperation = 4'b0110; #1;
    total++;
    if ({result, zero, lt, gt} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL sub_equal actual=%h/%b%b%b expected=0/100", result, zero, lt, gt);
    end
    data1 = 32'hFFFFFFFE; data2 = 32'd3; aluoperation = 4'b0111; #1;
    total++;
    if ({result, lt, gt} !== {32'd1, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL slt_neg actual=%h lt=%b gt=%b expected=1 lt=1 gt=0", result, lt, gt);
    end
    aluoperation = 4'b1001; #1;
    total++;
    if ({result, zero} !== {32'd0, 1'b1}) begin
      bad++; $display("[TB] FAIL sltu_neg actual=%h zero=%b expected=0 zero=1", result, zero);
    end
    aluoperation = 4'b0010; #1;
    total++;
    if ({result, zero} !== {32'd1, 1'b0}) begin
      bad++; $display("[TB] FAIL add_wrap actual=%h zero=%b expected=1 zero=0", result, zero);
    end
    data1 = 32'd5; data2 = 32'hFFFFFFFF; aluoperation = 4'b0111; #1;
    total++;
    if ({result, zero, lt, gt} !== {32'd0, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("[TB] FAIL slt_gt actual=%h/%b%b%b expected=0/101", result, zero, lt, gt);
    end
`ifdef ALU_OVF_EN
    data1 = 32'h7FFFFFFF; data2 = 32'd1; aluoperation = 4'b0010; #1;
    total++;
    if ({result, ovf} !== {32'h80000000, 1'b1}) begin
      bad++; $display("[TB] FAIL ovf_add actual=%h ovf=%b expected=80000000 ovf=1", result, ovf);
    end
    data1 = 32'h80000000; data2 = 32'd1; aluoperation = 4'b0110; #1;
    total++;
    if ({result, ovf} !== {32'h7FFFFFFF, 1'b1}) begin
      bad++; $display("[TB] FAIL ovf_sub actual=%h ovf=%b expected=7fffffff ovf=1", result, ovf);
    end
    aluoperation = 4'b0001; #1;
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("[TB] FAIL ovf_other actual=%b expected=0", ovf);
    end
`endif
  endtask

  task automatic test_alu_ops;
    logic [3:0]  ops  [13];
    logic [31:0] exps [13];
    ops  = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1000,
             4'b0110, 4'b0111, 4'b1001, 4'b1100, 4'b1010, 4'b1111};
    exps = '{32'h00000000, 32'h800001F4, 32'h800001F4, 32'h800001F4, 32'h00000F00,
             32'h0800000F, 32'hF800000F, 32'h7FFFFFEC, 32'h00000001, 32'h00000000,
             32'h7FFFFE0B, 32'h00000000, 32'h00000000};
    @(negedge clk);
    data1 = 32'h800000F0; data2 = 32'h00000104;
    for (int i = 0; i < 13; i++) begin
      aluoperation = ops[i]; #1;
      total++;
      if ({result, zero, lt, gt} !== {exps[i], exps[i] == 32'h0, 1'b1, 1'b0}) begin
        bad++;
        $display("[TB] FAIL alu_op_%b actual=%h z=%b lt=%b gt=%b expected=%h z=%b lt=1 gt=0",
                 ops[i], result, zero, lt, gt, exps[i], exps[i] == 32'h0);
      end
    end
  endtask

  task automatic test_adders;
    pc = 32'd10; imm = 32'hFFFFFFFC; #1;
    total++;
    if ({nfpc, branchedpc} !== {32'd11, 32'd7}) begin
      bad++; $display("[TB] FAIL pc_backward actual=%h/%h expected=0000000b/00000007", nfpc, branchedpc);
    end
    pc = 32'hFFFFFFFF; imm = 32'd3; #1;
    total++;
    if ({nfpc, branchedpc} !== {32'd0, 32'd3}) begin
      bad++; $display("[TB] FAIL pc_wrap actual=%h/%h expected=00000000/00000003", nfpc, branchedpc);
    end
  endtask

  task automatic test_memory;
    write_word(32'h00000104, 32'h12345678);
    @(negedge clk); set_addr(32'h4); memread = 1'b1; #1;
    total++;
    if (readdata !== 32'h12345678) begin
      bad++; $display("[TB] FAIL mem_alias_read actual=%h expected=12345678", readdata);
    end
    memread = 1'b0; #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL mem_read_disabled actual=%h expected=00000000", readdata);
    end
    set_addr(32'h5); memread = 1'b1; #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL mem_other_addr actual=%h expected=00000000", readdata);
    end
  endtask

  task automatic test_back_to_back;
    write_word(32'd9, 32'd1);
    @(negedge clk);
    set_addr(32'd9); writedata = 32'd2; memwrite = 1'b1; memread = 1'b1; #1;
    total++;
    if (readdata !== 32'd1) begin
      bad++; $display("[TB] FAIL rw_before_edge actual=%h expected=00000001", readdata);
    end
    @(posedge clk); #1;
    memwrite = 1'b0;
    total++;
    if (readdata !== 32'd2) begin
      bad++; $display("[TB] FAIL rw_after_edge actual=%h expected=00000002", readdata);
    end
  endtask

  task automatic test_reset_blocks_write;
    @(negedge clk);
    rst = 1'b1; set_addr(32'd3); writedata = 32'hCAFEF00D; memwrite = 1'b1; memread = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); memwrite = 1'b0; #1; rst = 1'b0; #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_blocks_write actual=%h expected=00000000", readdata);
    end
  endtask

  initial begin
    test_reset;
    test_alu_flags;
    test_alu_ops;
    test_adders;
    test_memory;
    test_back_to_back;
    test_reset_blocks_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
